axis_fifo_ctrl: RTL and testbench

AXIS_FIFO_CTRL -- requirements
Module: axis_fifo_ctrl

---
 rtl/axis_fifo_pkg.sv | 29 ++
 rtl/axis_fifo_ctrl_if.sv | 26 ++
 rtl/axis_fifo_ctrl_memdp.sv | 56 +++++
 rtl/axis_fifo_ctrl.sv | 128 ++++++++++++
 tb/tb_axis_fifo_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared definitions for the AXI4-Stream FIFO controller: width helpers and the
// canonical beat layout ({tlast, tdata}, tlast in the MSB).
package axis_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 16;

  // Beat as stored in the array: tlast rides above the payload.
  typedef struct packed {
    logic                          tlast;
    logic [DEFAULT_DATA_WIDTH-1:0] tdata;
  } beat_t;

  // Pointer width: wraps naturally modulo a power-of-two depth.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Array count spans 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Occupancy spans 0..depth+1 (array plus output register).
  function automatic int occ_width(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/axis_fifo_ctrl_if.sv
// One AXI4-Stream link. A beat transfers on a rising edge where tvalid && tready;
// once tvalid is high, tdata/tlast stay stable and tvalid stays high until that transfer.
interface axis_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_fifo_ctrl_memdp.sv
// Dual-port storage array: one synchronous write port and READ_PORTS registered
// read ports whose output registers reset to zero and hold when not read.
module memDP
  import axis_fifo_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 16,
  parameter  int READ_PORTS = 1,
  parameter  int BYPASS_EN  = 0,
  localparam int AW         = ptr_width(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [AW-1:0]                 waddr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic [READ_PORTS-1:0]         re,
  input  logic [READ_PORTS*AW-1:0]      raddr,
  output logic [READ_PORTS*WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0]            mem_q [DEPTH];
  logic [READ_PORTS*WIDTH-1:0] rdata_d;
  logic [READ_PORTS*WIDTH-1:0] rdata_q;

  // Contents are never cleared; only the read registers see reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    for (int p = 0; p < READ_PORTS; p++) begin
      if (re[p]) begin
        if ((BYPASS_EN != 0) && we && (waddr == raddr[p*AW +: AW])) begin
          rdata_d[p*WIDTH +: WIDTH] = wdata;
        end else begin
          rdata_d[p*WIDTH +: WIDTH] = mem_q[raddr[p*AW +: AW]];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axis_fifo_ctrl.sv
// AXI4-Stream FIFO controller: pointer/count bookkeeping around memDP, whose read
// register doubles as the registered m_axis output stage.
module axis_fifo_ctrl
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [$clog2(DEPTH+2)-1:0]    occupancy,
  output logic [$clog2(DEPTH+2)-1:0]    pkt_count
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam int OCC_W = occ_width(DEPTH);
  localparam int MEM_W = DATA_WIDTH + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             m_tvalid_q, m_tvalid_d;
  logic [OCC_W-1:0] pkt_q, pkt_d;

  logic             wr_en;
  logic             rd_en;
  logic             out_fire;
  logic             arr_full;
  logic             arr_empty;
  logic [MEM_W-1:0] mem_wdata;
  logic [MEM_W-1:0] mem_rdata;

  assign arr_full  = (count_q == CNT_W'(DEPTH));
  assign arr_empty = (count_q == '0);

  // Gated by reset_n so tready is low during reset and high right after release.
  assign s_axis_tready = reset_n & ~arr_full;

  assign wr_en    = s_axis_tvalid & s_axis_tready;
  assign rd_en    = ~arr_empty & (~m_tvalid_q | m_axis_tready);
  assign out_fire = m_tvalid_q & m_axis_tready;

  assign mem_wdata = {s_axis_tlast, s_axis_tdata};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Output valid: a read reloads the stage; otherwise a taken beat empties it.
  always_comb begin
    m_tvalid_d = m_tvalid_q;
    if (rd_en) begin
      m_tvalid_d = 1'b1;
    end else if (m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_comb begin
    pkt_d = pkt_q;
    case ({wr_en & s_axis_tlast, out_fire & m_axis_tlast})
      2'b10:   pkt_d = pkt_q + OCC_W'(1);
      2'b01:   pkt_d = pkt_q - OCC_W'(1);
      default: pkt_d = pkt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      m_tvalid_q <= 1'b0;
      pkt_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      m_tvalid_q <= m_tvalid_d;
      pkt_q      <= pkt_d;
    end
  end

  memDP #(
    .WIDTH      (MEM_W),
    .DEPTH      (DEPTH),
    .READ_PORTS (1),
    .BYPASS_EN  (0)
  ) u_mem (
    .clk   (clock),
    .rst   (~reset_n),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (mem_wdata),
    .re    (rd_en),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = mem_rdata[DATA_WIDTH-1:0];
  assign m_axis_tlast  = mem_rdata[DATA_WIDTH];
  assign occupancy     = OCC_W'(count_q) + OCC_W'(m_tvalid_q);
  assign pkt_count     = pkt_q;

endmodule

// File: tb/tb_axis_fifo_ctrl.sv
// Bench for axis_fifo_ctrl: directed scenarios plus randomized traffic against a
// queue model of the FIFO contents.
module tb_axis_fifo_ctrl;
  import axis_fifo_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int OW    = $clog2(DEPTH + 2);

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic [OW-1:0] occupancy;
  logic [OW-1:0] pkt_count;

  axis_fifo_ctrl_if #(.DATA_WIDTH(DW)) s_if ();
  axis_fifo_ctrl_if #(.DATA_WIDTH(DW)) m_if ();

  axis_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .s_axis_tvalid (s_if.tvalid),
    .s_axis_tready (s_if.tready),
    .s_axis_tdata  (s_if.tdata),
    .s_axis_tlast  (s_if.tlast),
    .m_axis_tvalid (m_if.tvalid),
    .m_axis_tready (m_if.tready),
    .m_axis_tdata  (m_if.tdata),
    .m_axis_tlast  (m_if.tlast),
    .occupancy     (occupancy),
    .pkt_count     (pkt_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model / scoreboard ----------------
  int    n_checks = 0;
  int    n_fail   = 0;
  int    edge_n   = 0;
  beat_t exp_q[$];
  int    t_q[$];
  logic  exp_valid = 1'b0;
  logic  exp_ready = 1'b1;

  // A held beat is visible at the output once a full edge has passed since it was
  // accepted; everything not on the output counts against the DEPTH array slots.
  function automatic void calc_exp();
    exp_valid = (exp_q.size() > 0) && (t_q[0] < edge_n);
    exp_ready = ((exp_q.size() - (exp_valid ? 1 : 0)) != DEPTH);
  endfunction

  function automatic int model_pkts();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].tlast) n++;
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
    s_if.tvalid = v;
    s_if.tdata  = d;
    s_if.tlast  = l;
    m_if.tready = r;
  endtask

  task automatic step(output logic in_f, output logic out_f);
    @(posedge clock);
    in_f  = s_if.tvalid && exp_ready;
    out_f = exp_valid && m_if.tready;
    edge_n++;
    if (out_f) begin
      void'(exp_q.pop_front());
      void'(t_q.pop_front());
    end
    if (in_f) begin
      exp_q.push_back(beat_t'{tlast: s_if.tlast, tdata: s_if.tdata});
      t_q.push_back(edge_n);
    end
    @(negedge clock);
    calc_exp();
  endtask

  task automatic drain();
    logic i_f, o_f;
    int   k = 0;
    drive(1'b0, '0, 1'b0, 1'b1);
    while ((exp_q.size() != 0 || occupancy != '0) && k < 200) begin
      step(i_f, o_f);
      k++;
    end
    n_checks++;
    if (k >= 200) begin
      n_fail++;
      $display("FAIL drain_timeout: occupancy=%0d model=%0d after %0d cycles", occupancy, exp_q.size(), k);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++; if (s_if.tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b want 0", s_if.tready); end
    n_checks++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", m_if.tvalid); end
    n_checks++; if (m_if.tdata !== '0) begin n_fail++; $display("FAIL rst_tdata: got %h want 0", m_if.tdata); end
    n_checks++; if (m_if.tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast: got %b want 0", m_if.tlast); end
    n_checks++; if (occupancy !== '0) begin n_fail++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
    n_checks++; if (pkt_count !== '0) begin n_fail++; $display("FAIL rst_pkt: got %0d want 0", pkt_count); end
    reset_n = 1'b1;
    #1;
    n_checks++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL post_rst_tready: got %b want 1", s_if.tready); end
    exp_q.delete(); t_q.delete(); calc_exp();
  endtask

  task automatic test_single();
    logic i_f, o_f;
    drive(1'b1, 32'hA5, 1'b1, 1'b1);
    step(i_f, o_f);
    n_checks++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: tvalid got %b want 0", m_if.tvalid); end
    n_checks++; if (pkt_count !== OW'(1)) begin n_fail++; $display("FAIL single_pkt_up: got %0d want 1", pkt_count); end
    n_checks++; if (occupancy !== OW'(1)) begin n_fail++; $display("FAIL single_occ: got %0d want 1", occupancy); end
    drive(1'b0, '0, 1'b0, 1'b1);
    step(i_f, o_f);
    n_checks++; if (m_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", m_if.tvalid); end
    n_checks++; if (m_if.tdata !== 32'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", m_if.tdata); end
    n_checks++; if (m_if.tlast !== 1'b1) begin n_fail++; $display("FAIL single_last: got %b want 1", m_if.tlast); end
    step(i_f, o_f);
    n_checks++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL single_drop: tvalid got %b want 0", m_if.tvalid); end
    n_checks++; if (pkt_count !== '0) begin n_fail++; $display("FAIL single_pkt_down: got %0d want 0", pkt_count); end
    n_checks++; if (occupancy !== '0) begin n_fail++; $display("FAIL single_occ_empty: got %0d want 0", occupancy); end
  endtask

  task automatic test_full();
    logic i_f, o_f;
    for (int i = 0; i < 17; i++) begin
      n_checks++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL full_ready_%0d: got %b want 1", i, s_if.tready); end
      drive(1'b1, 32'h100 + i, (i == 16), 1'b0);
      step(i_f, o_f);
    end
    n_checks++; if (s_if.tready !== 1'b0) begin n_fail++; $display("FAIL full_tready_low: got %b want 0", s_if.tready); end
    n_checks++; if (occupancy !== OW'(17)) begin n_fail++; $display("FAIL full_occ: got %0d want 17", occupancy); end
    n_checks++; if (pkt_count !== OW'(1)) begin n_fail++; $display("FAIL full_pkt: got %0d want 1", pkt_count); end
    drive(1'b1, 32'hDEAD, 1'b0, 1'b0);
    step(i_f, o_f);
    n_checks++; if (occupancy !== OW'(17)) begin n_fail++; $display("FAIL full_no_accept: occ got %0d want 17", occupancy); end
    n_checks++; if (m_if.tdata !== 32'h100) begin n_fail++; $display("FAIL full_stall_data: got %h want 100", m_if.tdata); end
    drive(1'b0, '0, 1'b0, 1'b1);
    step(i_f, o_f);
    n_checks++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop: got %b want 1", s_if.tready); end
    n_checks++; if (occupancy !== OW'(16)) begin n_fail++; $display("FAIL full_occ_pop: got %0d want 16", occupancy); end
    n_checks++; if (m_if.tdata !== 32'h101) begin n_fail++; $display("FAIL full_next_data: got %h want 101", m_if.tdata); end
    for (int k = 1; k < 16; k++) begin
      step(i_f, o_f);
      n_checks++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h101 + k || m_if.tlast !== (k == 15)) begin
        n_fail++;
        $display("FAIL full_order_%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", k, m_if.tvalid, m_if.tdata, m_if.tlast, 32'h101 + k, (k == 15));
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic i_f, o_f;
    int   sent = 0, recv = 0, gaps = 0, max_occ = 0, cyc = 0;
    logic started = 1'b0;
    while (recv < 64 && cyc < 300) begin
      drive(sent < 64, DW'(sent), sent == 63, 1'b1);
      step(i_f, o_f);
      cyc++;
      if (i_f) sent++;
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      n_checks++;
      if (m_if.tvalid !== exp_valid) begin n_fail++; $display("FAIL b2b_valid: got %b want %b at cycle %0d", m_if.tvalid, exp_valid, cyc); end
      if (exp_valid) begin
        n_checks++;
        if (m_if.tdata !== DW'(recv)) begin n_fail++; $display("FAIL b2b_data: got %0d want %0d", m_if.tdata, recv); end
        recv++;
        started = 1'b1;
      end else if (started && recv < 64) begin
        gaps++;
      end
    end
    n_checks++; if (recv != 64) begin n_fail++; $display("FAIL b2b_count: got %0d want 64", recv); end
    n_checks++; if (gaps != 0) begin n_fail++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end
    n_checks++; if (max_occ > 2) begin n_fail++; $display("FAIL b2b_max_occ: got %0d want <=2", max_occ); end
    drain();
  endtask

  task automatic test_random();
    logic i_f, o_f;
    int   sent = 0, recv = 0, cyc = 0;
    while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      drive((sent < 1000) && ($urandom_range(0, 1) == 1), $urandom, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1));
      step(i_f, o_f);
      cyc++;
      if (i_f) sent++;
      if (o_f) recv++;
      n_checks++; if (m_if.tvalid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid: got %b want %b cyc %0d", m_if.tvalid, exp_valid, cyc); end
      n_checks++; if (s_if.tready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready: got %b want %b cyc %0d", s_if.tready, exp_ready, cyc); end
      n_checks++; if (occupancy !== OW'(exp_q.size())) begin n_fail++; $display("FAIL rnd_occ: got %0d want %0d cyc %0d", occupancy, exp_q.size(), cyc); end
      n_checks++; if (pkt_count !== OW'(model_pkts())) begin n_fail++; $display("FAIL rnd_pkt: got %0d want %0d cyc %0d", pkt_count, model_pkts(), cyc); end
      if (exp_valid) begin
        n_checks++;
        if (m_if.tdata !== exp_q[0].tdata || m_if.tlast !== exp_q[0].tlast) begin
          n_fail++;
          $display("FAIL rnd_beat: got %h/%b want %h/%b cyc %0d", m_if.tdata, m_if.tlast, exp_q[0].tdata, exp_q[0].tlast, cyc);
        end
      end
    end
    n_checks++; if (recv != 1000) begin n_fail++; $display("FAIL rnd_total: got %0d want 1000 in %0d cycles", recv, cyc); end
    drain();
  endtask

  task automatic test_reset_mid();
    logic i_f, o_f;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h300 + i, (i == 2), 1'b0);
      step(i_f, o_f);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (occupancy !== OW'(5)) begin n_fail++; $display("FAIL mid_occ5: got %0d want 5", occupancy); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", m_if.tvalid); end
    n_checks++; if (m_if.tdata !== '0) begin n_fail++; $display("FAIL mid_rst_data: got %h want 0", m_if.tdata); end
    n_checks++; if (occupancy !== '0) begin n_fail++; $display("FAIL mid_rst_occ: got %0d want 0", occupancy); end
    n_checks++; if (pkt_count !== '0) begin n_fail++; $display("FAIL mid_rst_pkt: got %0d want 0", pkt_count); end
    n_checks++; if (s_if.tready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", s_if.tready); end
    exp_q.delete(); t_q.delete();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    calc_exp();
    #1;
    n_checks++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL mid_post_ready: got %b want 1", s_if.tready); end
    drive(1'b1, 32'h5A5A_0001, 1'b1, 1'b1);
    step(i_f, o_f);
    drive(1'b0, '0, 1'b0, 1'b1);
    step(i_f, o_f);
    n_checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h5A5A_0001 || m_if.tlast !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_first_beat: got v=%b d=%h l=%b want v=1 d=5a5a0001 l=1", m_if.tvalid, m_if.tdata, m_if.tlast);
    end
    step(i_f, o_f);
    n_checks++; if (occupancy !== '0 || pkt_count !== '0) begin n_fail++; $display("FAIL mid_final_empty: occ=%0d pkt=%0d want 0/0", occupancy, pkt_count); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
